// File: rtl/key_click_decoder_if.sv
// key_click_decoder_if: valid/ready event channel between the click decoder
// (master) and the downstream flash/control logic (slave).
interface key_click_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_count;

  modport master (
    output evt_valid,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_count,
    output evt_ready
  );
endinterface

// File: rtl/key_click_decoder.sv
// key_click_decoder: groups debounced key-release pulses into click bursts
// (single/double/... up to MAX_CLICKS) and hands completed bursts to the
// consumer through a valid/ready channel.
// Compile-time option: define KEY_EVT_FIFO_EN for a 4-entry event FIFO;
// otherwise a single holding register buffers one event.
module key_click_decoder #(
  parameter int GAP_CYCLES = 15_000_000,
  parameter int MAX_CLICKS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_pulse,
  key_click_decoder_if.master    evt,
  output logic                   burst_active,
  output logic                   evt_ovf
);

  localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);
  localparam logic [2:0]  MAX_C    = 3'(MAX_CLICKS);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]  click_cnt_q, click_cnt_d;
  logic [2:0]  click_inc;
  logic        emit;
  logic [2:0]  emit_count;

  logic        evt_ovf_q, evt_ovf_d;
  logic        full;
  logic        valid;
  logic [2:0]  head_count;
  logic        pop;
  logic        push;

  // Burst collection: next state, counters and the emit strobe.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    click_cnt_d = click_cnt_q;
    emit        = 1'b0;
    emit_count  = 3'd0;
    click_inc   = click_cnt_q + 3'd1;
    case (state_q)
      IDLE: begin
        if (key_pulse) begin
          gap_cnt_d = 24'd0;
          if (MAX_C == 3'd1) begin
            // A single click already completes the burst.
            emit        = 1'b1;
            emit_count  = 3'd1;
            click_cnt_d = 3'd0;
          end else begin
            click_cnt_d = 3'd1;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (key_pulse) begin
          // A pulse always wins over a coincident timeout.
          gap_cnt_d = 24'd0;
          if (click_inc == MAX_C) begin
            emit        = 1'b1;
            emit_count  = click_inc;
            click_cnt_d = 3'd0;
            state_d     = IDLE;
          end else begin
            click_cnt_d = click_inc;
          end
        end else if (gap_cnt_q == GAP_LAST) begin
          emit        = 1'b1;
          emit_count  = click_cnt_q;
          gap_cnt_d   = 24'd0;
          click_cnt_d = 3'd0;
          state_d     = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 24'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gap_cnt_d   = 24'd0;
        click_cnt_d = 3'd0;
      end
    endcase
  end

  // FSM and burst counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_cnt_q   <= 24'd0;
      click_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      click_cnt_q <= click_cnt_d;
    end
  end

  // A pop frees a slot on the same edge, so a full store still accepts a push then.
  always_comb begin
    pop       = valid & evt.evt_ready;
    push      = emit & (~full | pop);
    evt_ovf_d = evt_ovf_q | (emit & full & ~pop);
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_ovf_q <= 1'b0;
    end else begin
      evt_ovf_q <= evt_ovf_d;
    end
  end

`ifdef KEY_EVT_FIFO_EN
  logic [2:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] occ_q, occ_d;

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {1'b0, push};
    rd_ptr_d   = rd_ptr_q + {1'b0, pop};
    occ_d      = occ_q + {2'b00, push} - {2'b00, pop};
    full       = (occ_q == 3'd4);
    valid      = (occ_q != 3'd0);
    head_count = mem_q[rd_ptr_q];
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Event storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= emit_count;
    end
  end
`else
  logic       hold_valid_q, hold_valid_d;
  logic [2:0] hold_count_q, hold_count_d;

  // Single holding register: a push overrides a same-edge pop.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_count_d = hold_count_q;
    if (push) begin
      hold_valid_d = 1'b1;
      hold_count_d = emit_count;
    end else if (pop) begin
      hold_valid_d = 1'b0;
      hold_count_d = 3'd0;
    end
    full       = hold_valid_q;
    valid      = hold_valid_q;
    head_count = hold_count_q;
  end

  // Holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_count_q <= 3'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_count_q <= hold_count_d;
    end
  end
`endif

  // Output mapping; the count reads zero whenever no event is offered.
  always_comb begin
    evt.evt_valid = valid;
    evt.evt_count = valid ? head_count : 3'd0;
    burst_active  = (state_q == WAIT);
    evt_ovf       = evt_ovf_q;
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: directed scenarios plus random pulse trains, checked
// against a time-stamp based model of click bursts and an event queue.
module tb_key_click_decoder;
  localparam int GAP  = 20;
  localparam int MAXC = 3;
`ifdef KEY_EVT_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic key_pulse;
  logic burst_active;
  logic evt_ovf;

  key_click_decoder_if evt_if ();

  key_click_decoder #(
    .GAP_CYCLES(GAP),
    .MAX_CLICKS(MAXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pulse   (key_pulse),
    .evt         (evt_if),
    .burst_active(burst_active),
    .evt_ovf     (evt_ovf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a burst is a pulse count plus the edge index of its last
  // pulse; it ends GAP edges after that pulse or when the count hits MAXC.
  int cyc     = 0;
  bit m_burst = 0;
  int m_clicks = 0;
  int m_last  = 0;
  int m_q[$];
  bit m_ovf   = 0;

  function automatic logic [5:0] exp_vec();
    logic [2:0] c;
    c = (m_q.size() > 0) ? 3'(m_q[0]) : 3'd0;
    return {m_q.size() > 0, c, m_burst, m_ovf};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {evt_if.evt_valid, evt_if.evt_count, burst_active, evt_ovf};
  endfunction

  // Drive one clock worth of inputs and advance the model on that edge.
  task automatic step(input bit p, input bit r, input bit rs);
    int  emitted;
    bit  pop;
    key_pulse        = p;
    evt_if.evt_ready = r;
    rst              = rs;
    @(posedge clk);
    if (rs) begin
      cyc = 0; m_burst = 0; m_clicks = 0; m_last = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      cyc++;
      emitted = 0;
      pop = (m_q.size() > 0) && r;
      if (p) begin
        m_clicks = m_burst ? m_clicks + 1 : 1;
        m_burst  = 1;
        m_last   = cyc;
        if (m_clicks == MAXC) begin
          emitted = m_clicks;
          m_burst = 0;
        end
      end else if (m_burst && (cyc - m_last == GAP)) begin
        emitted = m_clicks;
        m_burst = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (emitted > 0) begin
        if (m_q.size() < CAP) m_q.push_back(emitted);
        else m_ovf = 1;
      end
    end
    #1;
    key_pulse = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1);
      n_total++;
      if (dut_vec() !== 6'd0) begin
        n_bad++;
        $display("FAIL reset i=%0d got=%b want=%b", i, dut_vec(), 6'd0);
      end
    end
  endtask

  task automatic test_single();
    step(1, 1, 0);
    n_total++;
    if (burst_active !== 1'b1) begin
      n_bad++;
      $display("FAIL single_burst_rise got=%b want=1", burst_active);
    end
    for (int i = 1; i <= 22; i++) begin
      step(0, 1, 0);
      n_total++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL single i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (i == 20) begin
        n_total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_count !== 3'd1 || burst_active !== 1'b0) begin
          n_bad++;
          $display("FAIL single_timeout got v=%b c=%0d b=%b want v=1 c=1 b=0",
                   evt_if.evt_valid, evt_if.evt_count, burst_active);
        end
      end
    end
  endtask

  task automatic test_double();
    int n_evt;
    int first_cnt;
    // Two pulses 10 clocks apart form one burst.
    n_evt = 0; first_cnt = 0;
    step(1, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 1; i <= 24; i++) begin
      step(0, 1, 0);
      n_total++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL double i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (evt_if.evt_valid === 1'b1) begin
        n_evt++;
        first_cnt = evt_if.evt_count;
      end
    end
    n_total++;
    if (n_evt != 1 || first_cnt != 2) begin
      n_bad++;
      $display("FAIL double_events got n=%0d cnt=%0d want n=1 cnt=2", n_evt, first_cnt);
    end
    // Second pulse one clock after the timeout edge starts a new burst.
    n_evt = 0;
    step(1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0);
      if (evt_if.evt_valid === 1'b1) n_evt++;
    end
    step(1, 1, 0);
    if (evt_if.evt_valid === 1'b1) n_evt++;
    for (int i = 1; i <= 24; i++) begin
      step(0, 1, 0);
      n_total++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL double_apart i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (evt_if.evt_valid === 1'b1) n_evt++;
    end
    n_total++;
    if (n_evt != 2) begin
      n_bad++;
      $display("FAIL double_apart_events got=%0d want=2", n_evt);
    end
  endtask

  task automatic test_triple();
    int n_evt;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0);
      if (k < 2) for (int i = 0; i < 4; i++) step(0, 1, 0);
    end
    n_total++;
    if (evt_if.evt_valid !== 1'b1 || evt_if.evt_count !== 3'd3 || burst_active !== 1'b0) begin
      n_bad++;
      $display("FAIL triple_max got v=%b c=%0d b=%b want v=1 c=3 b=0",
               evt_if.evt_valid, evt_if.evt_count, burst_active);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(1, 1, 0);
    n_evt = 0;
    for (int i = 1; i <= 22; i++) begin
      step(0, 1, 0);
      n_total++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL triple_next i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (evt_if.evt_valid === 1'b1 && evt_if.evt_count === 3'd1) n_evt++;
    end
    n_total++;
    if (n_evt != 1) begin
      n_bad++;
      $display("FAIL triple_next_events got=%0d want=1", n_evt);
    end
  endtask

  task automatic test_exact_timeout();
    step(1, 1, 0);
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    step(1, 1, 0);
    n_total++;
    if (evt_if.evt_valid !== 1'b0 || burst_active !== 1'b1) begin
      n_bad++;
      $display("FAIL exact_timeout got v=%b b=%b want v=0 b=1", evt_if.evt_valid, burst_active);
    end
    for (int i = 1; i <= 21; i++) begin
      step(0, 1, 0);
      n_total++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL exact_timeout_run i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
      end
      if (i == 20) begin
        n_total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_count !== 3'd2) begin
          n_bad++;
          $display("FAIL exact_timeout_cnt got v=%b c=%0d want v=1 c=2",
                   evt_if.evt_valid, evt_if.evt_count);
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int b = 1; b <= 5; b++) begin
      step(1, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0);
      n_total++;
      if (evt_ovf !== (b > CAP) || evt_if.evt_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL overflow b=%0d got ovf=%b v=%b want ovf=%b v=1",
                 b, evt_ovf, evt_if.evt_valid, (b > CAP));
      end
    end
    // Drain with ready high: one event per clock, no bubbles.
    for (int k = 0; k < CAP; k++) begin
      n_total++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_count !== 3'd1) begin
        n_bad++;
        $display("FAIL drain k=%0d got v=%b c=%0d want v=1 c=1",
                 k, evt_if.evt_valid, evt_if.evt_count);
      end
      step(0, 1, 0);
    end
    n_total++;
    if (dut_vec() !== exp_vec() || evt_if.evt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_empty got=%b want=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 0, 1);
    n_total++;
    if (dut_vec() !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_mid got=%b want=%b", dut_vec(), 6'd0);
    end
    step(0, 1, 0);
    n_total++;
    if (dut_vec() !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_mid_after got=%b want=%b", dut_vec(), 6'd0);
    end
    step(1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    n_total++;
    if (evt_if.evt_valid !== 1'b1 || evt_if.evt_count !== 3'd1 || evt_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_event got v=%b c=%0d o=%b want v=1 c=1 o=0",
               evt_if.evt_valid, evt_if.evt_count, evt_ovf);
    end
    step(0, 1, 0);
  endtask

  task automatic test_random();
    bit p, r, rs;
    int pct;
    for (int i = 0; i < 3000; i++) begin
      pct = ((i / 400) % 2 == 0) ? 12 : 4;
      p   = ($urandom_range(0, 99) < pct);
      r   = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 999) == 0);
      step(p, r, rs);
      n_total++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random i=%0d p=%b r=%b rs=%b got=%b want=%b",
                 i, p, r, rs, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    key_pulse        = 1'b0;
    evt_if.evt_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_double();
    test_triple();
    test_exact_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
